// File: rtl/dcache_stall_ctrl.sv
// Miss sequencer for the MEM-stage data cache.
// On a tag miss it stalls the pipeline, optionally writes back the dirty
// victim line, allocates the new line from memory, refills the arrays for
// one cycle and then lets the pending access complete as a hit.
module dcache_stall_ctrl #(
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 5,
  localparam int TAG_W   = 32 - INDEX_W - OFFSET_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic              hit_i,
  input  logic              dirty_i,
  input  logic [TAG_W-1:0]  victim_tag_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic              tag_we_o,
  output logic              data_we_o,
  output logic              set_dirty_o,
  output logic [15:0]       miss_cnt_o
);

  localparam int LINE_W = 32 - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILL
  } state_t;

  state_t             state_q, state_d;
  logic               mem_enable_q, mem_enable_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        miss_cnt_q, miss_cnt_d;
  logic [LINE_W-1:0]  line_addr_q, line_addr_d;
  logic [TAG_W-1:0]   victim_tag_q, victim_tag_d;
  logic               write_q, write_d;

  logic               stall;
  logic               tag_we;
  logic               data_we;
  logic               set_dirty;
  logic               ack_seen;

  // Byte offset within the line never reaches memory or the latches.
  logic               unused_offset;
  assign unused_offset = ^addr_i[OFFSET_W-1:0];

  // Next-state, memory request and array write-enable decode.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    miss_cnt_d   = miss_cnt_q;
    line_addr_d  = line_addr_q;
    victim_tag_d = victim_tag_q;
    write_d      = write_q;
    stall        = 1'b0;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    set_dirty    = 1'b0;
    ack_seen     = mem_ack_i && mem_enable_q;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (hit_i) begin
            if (write_i) begin
              data_we   = 1'b1;
              set_dirty = 1'b1;
            end
          end else begin
            stall        = 1'b1;
            line_addr_d  = addr_i[31:OFFSET_W];
            victim_tag_d = victim_tag_i;
            write_d      = write_i;
            if (miss_cnt_q != 16'hFFFF) begin
              miss_cnt_d = miss_cnt_q + 16'd1;
            end
            mem_enable_d = 1'b1;
            if (dirty_i) begin
              state_d     = WRITEBACK;
              mem_write_d = 1'b1;
              mem_addr_d  = {victim_tag_i, addr_i[INDEX_W+OFFSET_W-1:OFFSET_W],
                             {OFFSET_W{1'b0}}};
            end else begin
              state_d     = ALLOCATE;
              mem_write_d = 1'b0;
              mem_addr_d  = {addr_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
            end
          end
        end
      end

      WRITEBACK: begin
        stall      = 1'b1;
        mem_addr_d = {victim_tag_q, line_addr_q[INDEX_W-1:0], {OFFSET_W{1'b0}}};
        if (ack_seen) begin
          state_d     = ALLOCATE;
          mem_write_d = 1'b0;
          mem_addr_d  = {line_addr_q, {OFFSET_W{1'b0}}};
        end
      end

      ALLOCATE: begin
        stall = 1'b1;
        if (ack_seen) begin
          state_d      = REFILL;
          mem_enable_d = 1'b0;
        end
      end

      REFILL: begin
        stall     = 1'b1;
        tag_we    = 1'b1;
        data_we   = 1'b1;
        set_dirty = write_q;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, memory request, miss counter and latched access registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      miss_cnt_q   <= 16'h0;
      line_addr_q  <= '0;
      victim_tag_q <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      miss_cnt_q   <= miss_cnt_d;
      line_addr_q  <= line_addr_d;
      victim_tag_q <= victim_tag_d;
      write_q      <= write_d;
    end
  end

  assign stall_o      = stall;
  assign tag_we_o     = tag_we;
  assign data_we_o    = data_we;
  assign set_dirty_o  = set_dirty;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Scoreboard bench for dcache_stall_ctrl: the stimulus side pushes expected
// memory requests and refill results; a monitor pops them whenever the DUT
// issues a request or performs a refill. A responder acks each request after
// a latency chosen by the stimulus.
module tb_dcache_stall_ctrl;

  localparam int TAG_W = 23;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             req_i = 1'b0;
  logic             write_i = 1'b0;
  logic [31:0]      addr_i = 32'h0;
  logic             hit_i = 1'b0;
  logic             dirty_i = 1'b0;
  logic [TAG_W-1:0] victim_tag_i = '0;
  logic             mem_ack_i = 1'b0;
  logic             stall_o;
  logic             mem_enable_o;
  logic             mem_write_o;
  logic [31:0]      mem_addr_o;
  logic             tag_we_o;
  logic             data_we_o;
  logic             set_dirty_o;
  logic [15:0]      miss_cnt_o;

  dcache_stall_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .write_i      (write_i),
    .addr_i       (addr_i),
    .hit_i        (hit_i),
    .dirty_i      (dirty_i),
    .victim_tag_i (victim_tag_i),
    .mem_ack_i    (mem_ack_i),
    .stall_o      (stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .tag_we_o     (tag_we_o),
    .data_we_o    (data_we_o),
    .set_dirty_o  (set_dirty_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
  } mem_req_t;

  typedef struct packed {
    logic        dirty;
    logic [15:0] cnt;
  } refill_t;

  mem_req_t req_q[$];
  mem_req_t obs_q[$];
  refill_t  refill_q[$];
  int       lat_q[$];
  int       model_cnt = 0;
  logic     manual_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Line address of an access: byte offset cleared.
  function automatic logic [31:0] lineAddr(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  // Address of the victim line: stored tag above the access index.
  function automatic logic [31:0] victimAddr(input logic [TAG_W-1:0] tag,
                                             input logic [31:0] a);
    logic [31:0] t;
    t = 32'(tag);
    return (t << 9) | (((a >> 5) & 32'hF) << 5);
  endfunction

  // Memory responder: acks each new request after its queued latency.
  initial begin
    int          remaining;
    logic        p_en, p_wr, new_req, auto_ack;
    logic [31:0] p_addr;
    remaining = 0; p_en = 1'b0; p_wr = 1'b0; p_addr = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        remaining = 0;
        lat_q.delete();
        p_en = 1'b0;
        mem_ack_i = manual_ack;
        continue;
      end
      new_req = mem_enable_o && (!p_en || p_wr != mem_write_o || p_addr != mem_addr_o);
      p_en = mem_enable_o; p_wr = mem_write_o; p_addr = mem_addr_o;
      auto_ack = 1'b0;
      if (new_req && lat_q.size() > 0) remaining = lat_q.pop_front();
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) auto_ack = 1'b1;
      end
      mem_ack_i = auto_ack | manual_ack;
    end
  end

  // Monitor: compares every issued request and every refill with the scoreboard.
  initial begin
    logic        p_en, p_wr, new_req;
    logic [31:0] p_addr;
    mem_req_t    exp_req, got;
    refill_t     exp_ref;
    p_en = 1'b0; p_wr = 1'b0; p_addr = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        req_q.delete();
        refill_q.delete();
        p_en = 1'b0;
        continue;
      end
      if (p_en && p_wr && (!mem_enable_o || !mem_write_o || mem_addr_o != p_addr))
        checkOutput("wb_to_alloc_enable_held", 32'(mem_enable_o), 32'd1);
      new_req = mem_enable_o && (!p_en || p_wr != mem_write_o || p_addr != mem_addr_o);
      p_en = mem_enable_o; p_wr = mem_write_o; p_addr = mem_addr_o;
      if (new_req) begin
        got.wr = mem_write_o;
        got.addr = mem_addr_o;
        obs_q.push_back(got);
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_req: got wr=%0d addr=%0h expected none",
                   mem_write_o, mem_addr_o);
        end else begin
          exp_req = req_q.pop_front();
          checkOutput("req_write", 32'(mem_write_o), 32'(exp_req.wr));
          checkOutput("req_addr", mem_addr_o, exp_req.addr);
        end
      end
      if (tag_we_o) begin
        if (refill_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_refill: got tag_we=1 expected 0");
        end else begin
          exp_ref = refill_q.pop_front();
          checkOutput("refill_set_dirty", 32'(set_dirty_o), 32'(exp_ref.dirty));
          checkOutput("refill_data_we_stall", 32'({data_we_o, stall_o}), 32'd3);
          checkOutput("refill_miss_cnt", 32'(miss_cnt_o), 32'(exp_ref.cnt));
        end
      end
    end
  end

  // Drives one IDLE-cycle access and samples the combinational outputs.
  task automatic applyStimulus(input logic rq, input logic wr, input logic ht,
                               input logic [31:0] a);
    @(negedge clk_i);
    req_i = rq; write_i = wr; hit_i = ht; addr_i = a;
    dirty_i = 1'($urandom); victim_tag_i = TAG_W'($urandom);
    #1;
  endtask

  // Runs one complete miss, pushing the model's expectations first.
  task automatic doMiss(input logic [31:0] a, input logic [TAG_W-1:0] vt,
                        input logic d, input logic w, input int lat_wb,
                        input int lat_a);
    mem_req_t r;
    refill_t  f;
    int       stalls, expected;
    if (d) begin
      r.wr = 1'b1; r.addr = victimAddr(vt, a);
      req_q.push_back(r);
      lat_q.push_back(lat_wb);
    end
    r.wr = 1'b0; r.addr = lineAddr(a);
    req_q.push_back(r);
    lat_q.push_back(lat_a);
    if (model_cnt < 65535) model_cnt++;
    f.dirty = w; f.cnt = 16'(model_cnt);
    refill_q.push_back(f);
    expected = 2 + lat_a + (d ? lat_wb : 0);
    @(negedge clk_i);
    req_i = 1'b1; hit_i = 1'b0; write_i = w; addr_i = a;
    victim_tag_i = vt; dirty_i = d;
    #1;
    stalls = 0;
    while (stall_o && stalls < 400) begin
      stalls++;
      @(negedge clk_i);
      if (stalls == 1) begin
        hit_i = 1'b1;
        dirty_i = 1'($urandom);
        victim_tag_i = TAG_W'($urandom);
        addr_i = $urandom;
        write_i = 1'($urandom);
      end
      #1;
    end
    checkOutput("miss_stall_cycles", 32'(stalls), 32'(expected));
    @(negedge clk_i);
    req_i = 1'b0; hit_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem_req_t o;
    logic [31:0] a;

    // Reset state.
    #12;
    checkOutput("reset_mem_regs", 32'({mem_enable_o, mem_write_o}), 32'd0);
    checkOutput("reset_mem_addr", mem_addr_o, 32'h0);
    checkOutput("reset_miss_cnt", 32'(miss_cnt_o), 32'd0);
    checkOutput("reset_comb", 32'({stall_o, tag_we_o, data_we_o, set_dirty_o}), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Load hits: nothing happens.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, $urandom);
      checkOutput("load_hit_outputs",
                  32'({stall_o, data_we_o, set_dirty_o, tag_we_o, mem_enable_o}), 32'd0);
    end

    // Store hits: word write with dirty set, no stall, no memory request.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, $urandom);
      checkOutput("store_hit_outputs",
                  32'({stall_o, data_we_o, set_dirty_o, tag_we_o, mem_enable_o}), 32'b01100);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Clean load miss with a 10-cycle memory.
    obs_q.delete();
    doMiss(32'h0000_1234, 23'h0, 1'b0, 1'b0, 0, 10);
    checkOutput("clean_miss_req_count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      o = obs_q[0];
      checkOutput("clean_miss_addr", o.addr, 32'h0000_1220);
      checkOutput("clean_miss_write", 32'(o.wr), 32'd0);
    end
    checkOutput("cnt_after_clean_miss", 32'(miss_cnt_o), 32'd1);

    // Dirty store miss: writeback of victim, then allocate.
    obs_q.delete();
    doMiss(32'h0000_1234, 23'h7, 1'b1, 1'b1, 4, 6);
    checkOutput("dirty_miss_req_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() > 1) begin
      o = obs_q[0];
      checkOutput("dirty_wb_addr", o.addr, 32'h0000_0E20);
      checkOutput("dirty_wb_write", 32'(o.wr), 32'd1);
      o = obs_q[1];
      checkOutput("dirty_alloc_addr", o.addr, 32'h0000_1220);
      checkOutput("dirty_alloc_write", 32'(o.wr), 32'd0);
    end

    // Randomized mix of hits and misses.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3, 0))
        0: begin
          applyStimulus(1'b1, 1'b0, 1'b1, $urandom);
          checkOutput("rand_load_hit",
                      32'({stall_o, data_we_o, set_dirty_o, mem_enable_o}), 32'd0);
        end
        1: begin
          applyStimulus(1'b1, 1'b1, 1'b1, $urandom);
          checkOutput("rand_store_hit",
                      32'({stall_o, data_we_o, set_dirty_o, mem_enable_o}), 32'b0110);
        end
        default: begin
          doMiss($urandom, TAG_W'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(6, 1), $urandom_range(6, 1));
        end
      endcase
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of an allocate; a late ack must be ignored.
    a = 32'h0000_5678;
    lat_q.push_back(50);
    o.wr = 1'b0; o.addr = lineAddr(a);
    req_q.push_back(o);
    @(negedge clk_i);
    req_i = 1'b1; hit_i = 1'b0; write_i = 1'b0; dirty_i = 1'b0; addr_i = a;
    @(negedge clk_i);
    req_i = 1'b0; hit_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #2;
    checkOutput("alloc_enable_before_reset", 32'(mem_enable_o), 32'd1);
    rst_i = 1'b0;
    #1;
    checkOutput("reset_drops_enable", 32'(mem_enable_o), 32'd0);
    checkOutput("reset_clears_cnt", 32'(miss_cnt_o), 32'd0);
    checkOutput("reset_stall_low", 32'(stall_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    model_cnt = 0;
    #1 manual_ack = 1'b1;
    @(negedge clk_i);
    #1 manual_ack = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("late_ack_ignored",
                32'({stall_o, tag_we_o, data_we_o, mem_enable_o, mem_write_o}), 32'd0);
    checkOutput("late_ack_cnt", 32'(miss_cnt_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_5678);
    checkOutput("idle_after_reset_hit", 32'({stall_o, mem_enable_o}), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Counter saturation: preload near the top, then keep missing.
    @(negedge clk_i);
    force dut.miss_cnt_q = 16'hFFFE;
    repeat (2) @(negedge clk_i);
    release dut.miss_cnt_q;
    model_cnt = 65534;
    for (int i = 0; i < 3; i++) begin
      doMiss($urandom, TAG_W'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(3, 1), $urandom_range(3, 1));
    end
    checkOutput("cnt_saturated", 32'(miss_cnt_o), 32'h0000_FFFF);

    repeat (4) @(negedge clk_i);
    checkOutput("req_queue_drained", 32'(req_q.size()), 32'd0);
    checkOutput("refill_queue_drained", 32'(refill_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_stall_ctrl.md
Name: dcache_stall_ctrl

Overview:
- Miss sequencer for the MEM-stage data cache.
- Compares tag-check results from the tag array and, on a miss, runs a dirty-line writeback and a line allocate against off-chip memory using a req/ack handshake.
- Refills the cache line, then releases the pipeline.
- Generates the MemStall signal consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- INDEX_W, 4, cache set-index bits.
- OFFSET_W, 5, byte-offset bits; line size is 2^OFFSET_W bytes.
- TAG_W, 32-INDEX_W-OFFSET_W, tag bits; derived, not overridable.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_i  in  1  MEM stage has a load or store this cycle.
- write_i  in  1  access is a store; valid with req_i.
- addr_i  in  32  access byte address.
- hit_i  in  1  tag match and valid for addr_i; combinational from the tag array.
- dirty_i  in  1  dirty bit of the indexed line.
- victim_tag_i  in  TAG_W  tag currently stored at the indexed line.
- mem_ack_i  in  1  memory completion pulse, one cycle.
- stall_o  out  1  MemStall to the pipeline registers.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  memory request is a line write.
- mem_addr_o  out  32  line-aligned memory address.
- tag_we_o  out  1  write tag/valid into the tag array at the latched index.
- data_we_o  out  1  write the data array: refill line, or store-hit word.
- set_dirty_o  out  1  with tag_we_o or data_we_o: new dirty bit value.
- miss_cnt_o  out  16  saturating count of misses serviced.

Behaviour:
- States: IDLE, WRITEBACK, ALLOCATE, REFILL. State is registered.
- stall_o, tag_we_o, data_we_o and set_dirty_o are combinational from state and inputs. All other outputs are registered.
- Reset (rst_i=0, asynchronous):
  - state goes to IDLE.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, miss_cnt_o=0.
  - Latched address and latched victim tag are cleared.
  - Combinational outputs evaluate to 0 while in IDLE with req_i=0.
- Reset mid-transaction: drop mem_enable_o immediately. A later mem_ack_i is ignored.
- IDLE:
  - req_i=1, hit_i=1, write_i=1: data_we_o=1, set_dirty_o=1, stall_o=0.
  - req_i=1, hit_i=1, write_i=0: all outputs 0.
  - req_i=1, hit_i=0: stall_o=1 in the same cycle, so pipeline registers hold at the coming edge.
  - On that edge: latch addr_i and victim_tag_i, and increment miss_cnt_o (saturates at 16'hFFFF).
  - If dirty_i=1: go to WRITEBACK with mem_enable_o=1, mem_write_o=1, mem_addr_o={victim_tag_i, addr_i index, OFFSET_W'b0}.
  - If dirty_i=0: go to ALLOCATE with mem_enable_o=1, mem_write_o=0, mem_addr_o={addr_i[31:INDEX_W+OFFSET_W], index, OFFSET_W'b0}.
- WRITEBACK:
  - stall_o=1; hold all memory outputs stable.
  - On mem_ack_i=1: go to ALLOCATE. mem_addr_o becomes the latched address with line offset zeroed, mem_write_o=0, mem_enable_o stays 1.
- ALLOCATE:
  - stall_o=1.
  - On mem_ack_i=1: mem_enable_o=0, go to REFILL.
- REFILL, exactly one cycle:
  - stall_o=1, tag_we_o=1, data_we_o=1.
  - set_dirty_o equals the latched write flag; the store data is merged by the datapath.
  - Then go to IDLE.
- Next IDLE cycle: hit_i=1 is expected and stall_o=0, so the access completes.
  - If hit_i=0 again (conflict by a changed index), a new miss starts; this is legal.
- Handshake rules:
  - mem_enable_o rises only on the state-entry edge and stays high until the edge on which mem_ack_i=1 is sampled.
  - mem_ack_i with mem_enable_o=0 is ignored.
  - Back-to-back WRITEBACK to ALLOCATE keeps mem_enable_o high with no bubble.
- Miss latency is the memory latency, plus a writeback latency if dirty, plus 1 refill cycle, plus 1 cycle to complete the hit. There are no extra idle cycles.
- While not in IDLE: changes on req_i, write_i, addr_i, hit_i and dirty_i are ignored; latched values are used.
- Store miss sets the dirty bit at refill. Load miss clears it.

Test Plan:
- Reset with rst_i=0 in mid-ALLOCATE -> mem_enable_o falls without waiting for a clock edge; state is IDLE; miss_cnt_o=0; a later mem_ack_i causes no transition.
- Load hit: req_i=1, hit_i=1, write_i=0 -> stall_o=0, mem_enable_o=0, data_we_o=0 every cycle.
- Clean load miss: addr_i=32'h0000_1234, dirty_i=0, ack after 10 cycles -> stall_o high 12 cycles; mem_addr_o=32'h0000_1220 with mem_write_o=0; single REFILL cycle with tag_we_o=1 and set_dirty_o=0; miss_cnt_o=1.
- Dirty store miss: addr_i=32'h0000_1234, victim_tag_i=23'h7, dirty_i=1 -> first request mem_write_o=1 with mem_addr_o=32'h0000_0E20. After ack, mem_enable_o stays high with mem_write_o=0 and mem_addr_o=32'h0000_1220. REFILL has set_dirty_o=1.
- Store hit: req_i=1, write_i=1, hit_i=1 -> data_we_o=1, set_dirty_o=1, stall_o=0, no memory request.
- Counter saturation: force 65536 misses -> miss_cnt_o holds at 16'hFFFF.
